// File: rtl/packet_serializer_if.sv
// Byte-in / symbol-out bundle between the UART receive path, the serializer
// and the BPSK modulator.
interface packet_serializer_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       tx_bit;
    logic       tx_active;
    logic       bit_strobe;
    logic       packet_done;

    modport master (
        output byte_data, byte_valid,
        input  byte_ready, tx_bit, tx_active, bit_strobe, packet_done
    );

    modport slave (
        input  byte_data, byte_valid,
        output byte_ready, tx_bit, tx_active, bit_strobe, packet_done
    );
endinterface

// File: rtl/packet_serializer.sv
// Collects PACKET_BYTES bytes, then shifts them out LSB-first, one bit per
// SYMBOL_PERIOD clocks, pulsing packet_done after the final symbol.
//
// state | meaning
// IDLE  | buffer empty, byte_count = 0
// FILL  | 1..PACKET_BYTES-1 bytes held
// SEND  | serializing the buffer to the modulator
module packet_serializer #(
    parameter int PACKET_BYTES  = 4,
    parameter int SYMBOL_PERIOD = 16
) (
    input logic                  clk,
    input logic                  reset,
    input logic                  clear,
    packet_serializer_if.slave   bus
);
    localparam int PACKET_SIZE = 8 * PACKET_BYTES;
    localparam int SW = (SYMBOL_PERIOD > 1) ? $clog2(SYMBOL_PERIOD) : 1;
    localparam int BW = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
    localparam int CW = $clog2(PACKET_BYTES + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    localparam logic [SW-1:0] SYM_LAST  = SW'(SYMBOL_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(PACKET_SIZE - 1);
    localparam logic [CW-1:0] BYTE_LAST = CW'(PACKET_BYTES - 1);

    logic [1:0]             state;
    logic [CW-1:0]          byte_count;
    logic [SW-1:0]          sym_cnt;
    logic [BW-1:0]          bit_idx;
    logic [PACKET_SIZE-1:0] buffer;
    logic                   done_q;
    logic                   xfer;
    logic                   sending;

    // Ready drops combinationally under reset/clear so no byte slips in then.
    assign sending         = (state == SEND);
    assign bus.byte_ready  = !sending && !reset && !clear;
    assign xfer            = bus.byte_valid && bus.byte_ready;
    assign bus.tx_active   = sending;
    assign bus.tx_bit      = sending && buffer[bit_idx];
    assign bus.bit_strobe  = sending && (sym_cnt == '0);
    assign bus.packet_done = done_q;

    always_ff @(posedge clk) begin
        if (xfer) begin
            buffer[int'(byte_count) * 8 +: 8] <= bus.byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= IDLE;
            byte_count <= '0;
            sym_cnt    <= '0;
            bit_idx    <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, FILL: begin
                    if (xfer) begin
                        if (byte_count == BYTE_LAST) begin
                            state      <= SEND;
                            byte_count <= CW'(PACKET_BYTES);
                        end else begin
                            state      <= FILL;
                            byte_count <= byte_count + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (sym_cnt == SYM_LAST) begin
                        sym_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            state      <= IDLE;
                            bit_idx    <= '0;
                            byte_count <= '0;
                            done_q     <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        sym_cnt <= sym_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
